// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store unit controller. Each request is latched, checked
//               for alignment and range, sent to the data RAM, then answered.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    output logic [2:0]  ram_size,
    input  logic [31:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rfault_q, rfault_d;

    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_fault;
    logic        w_accept;

    // Word takes priority over half when both size bits are set, as in the RAM.
    always_comb begin
        if (req_size[1]) begin
            w_misaligned = (req_addr[1:0] != 2'b00);
        end else if (req_size[0]) begin
            w_misaligned = req_addr[0];
        end else begin
            w_misaligned = 1'b0;
        end
        w_out_of_range = (req_addr[31:7] != 25'd0);
        w_fault        = w_misaligned | w_out_of_range;
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign w_accept   = req_valid && req_ready;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        fault_d  = fault_q;
        rdata_d  = rdata_q;
        rfault_d = rfault_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    fault_d = w_fault;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d  = (we_q || fault_q) ? 32'd0 : ram_dout;
                rfault_d = fault_q;
                state_d  = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            size_q   <= 3'd0;
            fault_q  <= 1'b0;
            rdata_q  <= 32'd0;
            rfault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
            rfault_q <= rfault_d;
        end
    end

    // The RAM writes on the falling edge, so one ACCESS cycle is one write.
    assign ram_we     = (state_q == ACCESS) && we_q && !fault_q;
    assign ram_addr   = addr_q;
    assign ram_din    = wdata_q;
    assign ram_size   = size_q;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = rfault_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Directed vector bench for lsu_ctrl with a byte-wide RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [2:0]  ram_size;
    logic [31:0] ram_dout;

    int n_checks;
    int n_errors;
    int cyc;
    int ram_we_cnt;

    lsu_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_size   (ram_size),
        .ram_dout   (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // 128-byte little-endian RAM: writes on the falling edge, reads combinational.
    logic [7:0] mem [0:127];
    logic [7:0] b0, b1, b2, b3;

    always @(negedge clk) begin
        if (ram_we) begin
            ram_we_cnt = ram_we_cnt + 1;
            mem[ram_addr[6:0]] = ram_din[7:0];
            if (ram_size[1] || ram_size[0]) begin
                mem[ram_addr[6:0] + 7'd1] = ram_din[15:8];
            end
            if (ram_size[1]) begin
                mem[ram_addr[6:0] + 7'd2] = ram_din[23:16];
                mem[ram_addr[6:0] + 7'd3] = ram_din[31:24];
            end
        end
    end

    always_comb begin
        b0 = mem[ram_addr[6:0]];
        b1 = mem[ram_addr[6:0] + 7'd1];
        b2 = mem[ram_addr[6:0] + 7'd2];
        b3 = mem[ram_addr[6:0] + 7'd3];
        if (ram_size[1]) begin
            ram_dout = {b3, b2, b1, b0};
        end else if (ram_size[0]) begin
            ram_dout = {{16{b1[7] & ~ram_size[2]}}, b1, b0};
        end else begin
            ram_dout = {{24{b0[7] & ~ram_size[2]}}, b0};
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          hold;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called about 1 time unit after a rising edge with the DUT in IDLE.
    task automatic run_req(input int idx, input vec_t v, output int accept_cyc);
        string tag;
        tag = $sformatf("v%0d", idx);
        chk({tag, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_size   = v.size;
        resp_ready = 1'b0;
        ram_we_cnt = 0;
        @(posedge clk); #1;
        accept_cyc = cyc;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_size   = 3'd0;
        chk({tag, " resp_valid T+1"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, " req_ready access"}, {31'd0, req_ready}, 32'd0);
        chk({tag, " ram_addr"}, ram_addr, v.addr);
        chk({tag, " ram_din"}, ram_din, v.wdata);
        chk({tag, " ram_size"}, {29'd0, ram_size}, {29'd0, v.size});
        @(posedge clk); #1;
        chk({tag, " resp_valid T+2"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, " rdata"}, resp_rdata, v.exp_rdata);
        chk({tag, " fault"}, {31'd0, resp_fault}, {31'd0, v.exp_fault});
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            chk({tag, " hold resp_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({tag, " hold rdata"}, resp_rdata, v.exp_rdata);
            chk({tag, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, " resp_valid after"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, " req_ready after"}, {31'd0, req_ready}, 32'd1);
        chk({tag, " ram_we count"}, ram_we_cnt, (v.we && !v.exp_fault) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int prev_acc;
        vec_t v;

        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        ram_we_cnt = 0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_size   = 3'd0;
        resp_ready = 1'b0;

        //             we    addr        wdata          size    exp_rdata      flt   hold
        vecs[0]  = '{1'b1, 32'h00,  32'hCAFEF00D, 3'b010, 32'h00000000, 1'b0, 0};
        vecs[1]  = '{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0, 0};
        vecs[2]  = '{1'b0, 32'h10,  32'h00000000, 3'b010, 32'hDEADBEEF, 1'b0, 0};
        vecs[3]  = '{1'b1, 32'h21,  32'h00000080, 3'b000, 32'h00000000, 1'b0, 0};
        vecs[4]  = '{1'b0, 32'h21,  32'h00000000, 3'b000, 32'hFFFFFF80, 1'b0, 0};
        vecs[5]  = '{1'b0, 32'h21,  32'h00000000, 3'b100, 32'h00000080, 1'b0, 0};
        vecs[6]  = '{1'b1, 32'h02,  32'h11223344, 3'b010, 32'h00000000, 1'b1, 0};
        vecs[7]  = '{1'b1, 32'h100, 32'h55667788, 3'b010, 32'h00000000, 1'b1, 0};
        vecs[8]  = '{1'b0, 32'h00,  32'h00000000, 3'b010, 32'hCAFEF00D, 1'b0, 3};
        vecs[9]  = '{1'b0, 32'h11,  32'h00000000, 3'b001, 32'h00000000, 1'b1, 0};
        vecs[10] = '{1'b0, 32'h12,  32'h00000000, 3'b011, 32'h00000000, 1'b1, 0};
        vecs[11] = '{1'b0, 32'h12,  32'h00000000, 3'b001, 32'hFFFFDEAD, 1'b0, 0};
        vecs[12] = '{1'b0, 32'h12,  32'h00000000, 3'b101, 32'h0000DEAD, 1'b0, 0};
        vecs[13] = '{1'b0, 32'h80,  32'h00000000, 3'b000, 32'h00000000, 1'b1, 0};
        vecs[14] = '{1'b1, 32'h14,  32'h1234ABCD, 3'b001, 32'h00000000, 1'b0, 0};
        vecs[15] = '{1'b0, 32'h14,  32'h00000000, 3'b010, 32'h0000ABCD, 1'b0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("reset ram_we", {31'd0, ram_we}, 32'd0);
        chk("reset ram_addr", ram_addr, 32'd0);
        chk("reset ram_din", ram_din, 32'd0);
        chk("reset ram_size", {29'd0, ram_size}, 32'd0);
        rst = 1'b0;
        #1;
        chk("req_ready after reset", {31'd0, req_ready}, 32'd1);

        prev_acc = 0;
        for (int i = 0; i < 16; i++) begin
            run_req(i, vecs[i], acc);
            if (i > 0) begin
                chk($sformatf("v%0d accept spacing", i), acc - prev_acc, 3 + vecs[i-1].hold);
            end
            prev_acc = acc;
        end

        // Reset while a store is in ACCESS: the response must be dropped.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h12345678;
        req_size  = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort ram_we", {31'd0, ram_we}, 32'd0);
        chk("abort req_ready in rst", {31'd0, req_ready}, 32'd0);
        chk("abort ram_addr cleared", ram_addr, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort req_ready", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort no resp", {31'd0, resp_valid}, 32'd0);
        end
        v = '{1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 0};
        run_req(100, v, acc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous active-high reset, sampled on rising clk.
REQ-004 Port: req_valid  in  1  CPU memory request present.
REQ-005 Port: req_ready  out  1  block accepts a request this cycle.
REQ-006 Port: req_we  in  1  1 = store, 0 = load.
REQ-007 Port: req_addr  in  32  byte address.
REQ-008 Port: req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 Port: req_size  in  3  bit0 = half, bit1 = word, neither = byte, bit2 = unsigned load.
REQ-010 Port: resp_valid  out  1  response available.
REQ-011 Port: resp_ready  in  1  CPU accepts the response.
REQ-012 Port: resp_rdata  out  32  load result, already extended; 0 for stores and faults.
REQ-013 Port: resp_fault  out  1  access was misaligned or out of range; no memory effect.
REQ-014 Port: ram_addr  out  32  data RAM address.
REQ-015 Port: ram_din  out  32  data RAM write data.
REQ-016 Port: ram_we  out  1  data RAM write enable; the RAM writes on the falling clock edge.
REQ-017 Port: ram_size  out  3  data RAM access size, same encoding as req_size.
REQ-018 Port: ram_dout  in  32  data RAM combinational read data, already extended.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-020 IDLE: req_ready = 1; on req_valid, latch we, addr, wdata, size and the fault flag into registers and go to ACCESS.
REQ-021 ACCESS and RESP SHALL hold req_ready = 0; requests are ignored.
REQ-022 The fault flag SHALL be set when any of the following holds: size word with addr[1:0] != 0; size half (bit1 = 0) with addr[0] = 1; addr[31:7] != 0.
REQ-023 ram_addr, ram_din and ram_size SHALL always drive the latched registers.
REQ-024 ram_we SHALL be 1 only in ACCESS, with latched we = 1 and fault = 0, for exactly one cycle.
REQ-025 At the rising edge ending ACCESS, resp_rdata SHALL capture ram_dout for a non-faulting load and 0 otherwise, resp_fault SHALL capture the fault flag, and the FSM SHALL go to RESP.
REQ-026 RESP: resp_valid = 1, with resp_rdata and resp_fault held stable until the cycle with resp_ready = 1, after which the FSM goes to IDLE.
REQ-027 Latency: a request accepted at edge T SHALL give resp_valid at T+2; back-to-back throughput SHALL be one request per 3 cycles.
REQ-028 size with both bit0 and bit1 set SHALL be treated as word for the alignment check, matching the RAM's word priority.
REQ-029 resp_valid SHALL never assert without a prior accepted request, and exactly one response SHALL be produced per accepted request.

Reset
REQ-030 rst = 1 SHALL force IDLE and clear all of the following to 0: resp_valid, resp_rdata, resp_fault, ram_we and the latched registers.
REQ-031 rst asserted in ACCESS SHALL deassert ram_we from the next rising edge; the pending response SHALL be dropped.
REQ-032 During rst, req_ready SHALL be 0; it SHALL return to 1 in the first cycle after rst deasserts.

Verification
REQ-033 Store word 0xDEADBEEF to 0x10, then load word 0x10: load resp_rdata = 0xDEADBEEF, resp_fault = 0, and resp_valid two cycles after each accept.
REQ-034 Store byte 0x80 to 0x21, then load byte signed and unsigned from 0x21: results 0xFFFFFF80 and 0x00000080.
REQ-035 Store word to 0x02 (misaligned), then to 0x100 (out of range): both give resp_fault = 1, ram_we never asserts, and a later load of word 0x00 is unchanged.
REQ-036 Load with resp_ready held 0 for 3 cycles: resp_valid and resp_rdata stay stable, req_ready stays 0, and the block returns to IDLE one cycle after resp_ready = 1.
REQ-037 Assert rst during ACCESS of a store word 0x12345678 to 0x40: the state is IDLE, resp_valid = 0, no response is produced, and the next request completes normally.
